buf_alloc_ctrl: RTL and testbench

- Allocation controller in front of the 4-entry LFU replacement finder.
- Round-robin arbitrates new-buffer requests from NUM_REQ requesters and pulses new_buf_req to the finder.
- Captures the victim number from the finder and writes the victim back if it is dirty.
- Grants the victim to the winning requester and drives ref_buf_numbr so the fill is counted as an access.

---
 rtl/buf_alloc_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_buf_alloc_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_alloc_ctrl.sv
// Allocation controller in front of the 4-entry LFU replacement finder: round-robin
// request arbitration, victim lookup, dirty-victim write-back and one-cycle grant.
module buf_alloc_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int LFU_LAT    = 1,
  parameter int WB_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_buf,
  output logic               busy,
  output logic               new_buf_req,
  input  logic [1:0]         buf_num_replc,
  input  logic [1:0]         host_ref_buf,
  output logic [1:0]         ref_buf_numbr,
  input  logic               mark_dirty,
  input  logic [1:0]         mark_buf,
  output logic               wb_req,
  output logic [1:0]         wb_buf,
  input  logic               wb_ack,
  output logic               err_wb_to
);

  localparam int         PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] LAT_INIT = 2'(LFU_LAT);
  localparam logic [7:0] WB_LAST  = 8'(WB_TIMEOUT - 1);

  generate
    if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
      $fatal(1, "buf_alloc_ctrl: NUM_REQ must be within 2..8");
    end
    if ((LFU_LAT < 1) || (LFU_LAT > 3)) begin : g_bad_lfu_lat
      $fatal(1, "buf_alloc_ctrl: LFU_LAT must be within 1..3");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WB     = 2'd2,
    ST_GRANT  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   winner_r;
  logic [PTR_W-1:0]   pick_idx_s;
  logic [PTR_W-1:0]   rr_nxt_s;
  logic               pick_valid_s;
  logic [1:0]         lat_cnt_r;
  logic [1:0]         victim_r;
  logic [7:0]         wb_cnt_r;
  logic [3:0]         dirty_r;
  logic [3:0]         dirty_nxt_s;
  logic [3:0]         clr_s;
  logic               capture_s;
  logic               decide_s;
  logic               wb_timeout_s;
  logic [NUM_REQ-1:0] gnt_nxt_s;
  logic [1:0]         gnt_buf_nxt_s;
  logic               busy_nxt_s;
  logic               new_buf_req_nxt_s;
  logic               wb_req_nxt_s;
  logic [1:0]         wb_buf_nxt_s;
  logic               err_wb_to_nxt_s;

  // First set request bit at or above ptr, wrapping; returns {found, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [PTR_W-1:0]   ptr);
    logic             found;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] c;
    int               cand;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      c = PTR_W'(cand);
      if (!found && r[c]) begin
        found = 1'b1;
        idx   = c;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Arbitration result for the current request vector.
  always_comb begin
    {pick_valid_s, pick_idx_s} = rr_pick(req, rr_ptr_r);
  end

  // Victim is sampled on the last new_buf_req cycle; the following cycle decides WB vs GRANT.
  assign capture_s    = (state_r == ST_LOOKUP) && (lat_cnt_r == 2'd1);
  assign decide_s     = (state_r == ST_LOOKUP) && (lat_cnt_r == 2'd0);
  assign wb_timeout_s = (state_r == ST_WB) && !wb_ack && (wb_cnt_r == WB_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = ST_LOOKUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (decide_s) begin
          state_nxt_s = dirty_r[victim_r] ? ST_WB : ST_GRANT;
        end else begin
          state_nxt_s = ST_LOOKUP;
        end
      end
      ST_WB: begin
        if (wb_ack) begin
          state_nxt_s = ST_GRANT;
        end else if (wb_timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_GRANT: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed on the state being entered.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_nxt_s[i] = (state_nxt_s == ST_GRANT) && (winner_r == PTR_W'(i));
    end
    gnt_buf_nxt_s = (state_nxt_s == ST_GRANT) ? victim_r : 2'd0;
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
    if ((state_r == ST_IDLE) && pick_valid_s) begin
      new_buf_req_nxt_s = 1'b1;
    end else if ((state_r == ST_LOOKUP) && (lat_cnt_r > 2'd1)) begin
      new_buf_req_nxt_s = 1'b1;
    end else begin
      new_buf_req_nxt_s = 1'b0;
    end
    wb_req_nxt_s    = (state_nxt_s == ST_WB);
    wb_buf_nxt_s    = (state_nxt_s == ST_WB) ? victim_r : 2'd0;
    err_wb_to_nxt_s = wb_timeout_s;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= {NUM_REQ{1'b0}};
      gnt_buf     <= 2'd0;
      busy        <= 1'b0;
      new_buf_req <= 1'b0;
      wb_req      <= 1'b0;
      wb_buf      <= 2'd0;
      err_wb_to   <= 1'b0;
    end else begin
      gnt         <= gnt_nxt_s;
      gnt_buf     <= gnt_buf_nxt_s;
      busy        <= busy_nxt_s;
      new_buf_req <= new_buf_req_nxt_s;
      wb_req      <= wb_req_nxt_s;
      wb_buf      <= wb_buf_nxt_s;
      err_wb_to   <= err_wb_to_nxt_s;
    end
  end

  // Only the grant cycle redirects the finder's reference to the filled buffer.
  always_comb begin
    if (state_r == ST_GRANT) begin
      ref_buf_numbr = gnt_buf;
    end else begin
      ref_buf_numbr = host_ref_buf;
    end
  end

  // Pointer advance past the winner, with wrap.
  always_comb begin
    if (winner_r == PTR_W'(NUM_REQ - 1)) begin
      rr_nxt_s = {PTR_W{1'b0}};
    end else begin
      rr_nxt_s = winner_r + PTR_W'(1);
    end
  end

  // Dirty bits: a mark in the same cycle beats a grant or write-back clear.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      clr_s[b]       = ((state_r == ST_GRANT) || ((state_r == ST_WB) && wb_ack)) &&
                       (victim_r == 2'(b));
      dirty_nxt_s[b] = (mark_dirty && (mark_buf == 2'(b))) || (dirty_r[b] && !clr_s[b]);
    end
  end

  // Sequencing datapath: winner, pointer, latency and wait counters, victim, dirty bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r  <= {PTR_W{1'b0}};
      winner_r  <= {PTR_W{1'b0}};
      lat_cnt_r <= 2'd0;
      victim_r  <= 2'd0;
      wb_cnt_r  <= 8'd0;
      dirty_r   <= 4'd0;
    end else begin
      dirty_r <= dirty_nxt_s;
      if ((state_r == ST_IDLE) && pick_valid_s) begin
        winner_r  <= pick_idx_s;
        lat_cnt_r <= LAT_INIT;
      end else if ((state_r == ST_LOOKUP) && (lat_cnt_r != 2'd0)) begin
        lat_cnt_r <= lat_cnt_r - 2'd1;
      end else begin
        lat_cnt_r <= lat_cnt_r;
      end
      if (capture_s) begin
        victim_r <= buf_num_replc;
      end else begin
        victim_r <= victim_r;
      end
      if ((state_r == ST_WB) && (state_nxt_s == ST_WB)) begin
        wb_cnt_r <= wb_cnt_r + 8'd1;
      end else begin
        wb_cnt_r <= 8'd0;
      end
      if (state_r == ST_GRANT) begin
        rr_ptr_r <= rr_nxt_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_buf_alloc_ctrl.sv
// Directed bench for buf_alloc_ctrl: a phase-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_buf_alloc_ctrl;

  localparam int NR  = 4;
  localparam int LAT = 1;
  localparam int TO  = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] gnt;
  logic [1:0]    gnt_buf;
  logic          busy;
  logic          new_buf_req;
  logic [1:0]    buf_num_replc = 2'd0;
  logic [1:0]    host_ref_buf = 2'd1;
  logic [1:0]    ref_buf_numbr;
  logic          mark_dirty = 1'b0;
  logic [1:0]    mark_buf = 2'd0;
  logic          wb_req;
  logic [1:0]    wb_buf;
  logic          wb_ack = 1'b0;
  logic          err_wb_to;

  int total = 0;
  int bad   = 0;

  buf_alloc_ctrl #(.NUM_REQ(NR), .LFU_LAT(LAT), .WB_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_buf(gnt_buf), .busy(busy),
    .new_buf_req(new_buf_req), .buf_num_replc(buf_num_replc), .host_ref_buf(host_ref_buf),
    .ref_buf_numbr(ref_buf_numbr), .mark_dirty(mark_dirty), .mark_buf(mark_buf),
    .wb_req(wb_req), .wb_buf(wb_buf), .wb_ack(wb_ack), .err_wb_to(err_wb_to)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 lookup, 2 write-back, 3 grant.
  int         m_phase = 0;
  int         m_age   = 0;
  int         m_wbw   = 0;
  int         m_win   = 0;
  int         m_rr    = 0;
  logic [1:0] m_vic   = 2'd0;
  logic [3:0] m_dirty = 4'd0;
  logic       m_err   = 1'b0;

  function automatic int rr_first(input logic [NR-1:0] r, input int p);
    for (int i = 0; i < NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_age <= 0; m_wbw <= 0; m_win <= 0; m_rr <= 0;
      m_vic <= 2'd0; m_dirty <= 4'd0; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (mark_dirty && mark_buf == 2'(b)) m_dirty[b] <= 1'b1;
        else if ((m_phase == 3 || (m_phase == 2 && wb_ack)) && m_vic == 2'(b)) m_dirty[b] <= 1'b0;
      end
      case (m_phase)
        0: if (req != '0) begin
             m_win <= rr_first(req, m_rr); m_phase <= 1; m_age <= 1;
           end
        1: begin
             if (m_age == LAT) m_vic <= buf_num_replc;
             if (m_age == LAT + 1) begin
               m_phase <= m_dirty[m_vic] ? 2 : 3; m_wbw <= 0;
             end
             m_age <= m_age + 1;
           end
        2: if (wb_ack) m_phase <= 3;
           else if (m_wbw == TO - 1) begin m_phase <= 0; m_err <= 1'b1; end
           else m_wbw <= m_wbw + 1;
        3: begin m_phase <= 0; m_rr <= (m_win + 1) % NR; end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("gnt",     32'(gnt),     (m_phase == 3) ? 32'(1 << m_win) : 32'd0);
    check("gnt_buf", 32'(gnt_buf), (m_phase == 3) ? 32'(m_vic) : 32'd0);
    check("busy",    32'(busy),    32'(m_phase != 0));
    check("new_buf_req", 32'(new_buf_req), 32'(m_phase == 1 && m_age <= LAT));
    check("wb_req",  32'(wb_req),  32'(m_phase == 2));
    check("wb_buf",  32'(wb_buf),  (m_phase == 2) ? 32'(m_vic) : 32'd0);
    check("err_wb_to", 32'(err_wb_to), 32'(m_err));
    check("ref_buf_numbr", 32'(ref_buf_numbr), (m_phase == 3) ? 32'(m_vic) : 32'(host_ref_buf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sig_hi(input int which);
    case (which)
      0:       return gnt != '0;
      1:       return wb_req;
      2:       return err_wb_to;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output int n, output bit ok);
    n = 0;
    while (!sig_hi(which) && n < budget) begin
      tick();
      n++;
    end
    ok = sig_hi(which);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; wb_ack = 1'b0; mark_dirty = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  int         n;
  int         m;
  bit         ok;
  bit         gseen;
  int         ng;
  int         gt[5];
  logic [3:0] gv[5];
  logic [3:0] e2[5];

  initial begin
    e2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tick(); tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_new", 32'(new_buf_req), 32'd0);
    check("rst_wb_req", 32'(wb_req), 32'd0);
    check("rst_wb_buf", 32'(wb_buf), 32'd0);
    check("rst_err", 32'(err_wb_to), 32'd0);
    check("rst_gnt_buf", 32'(gnt_buf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single clean allocation.
    buf_num_replc = 2'd2; req = 4'b0001;
    tick();
    check("t1_new_hi", 32'(new_buf_req), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ref_host", 32'(ref_buf_numbr), 32'd1);
    tick();
    check("t1_new_lo", 32'(new_buf_req), 32'd0);
    check("t1_no_gnt_yet", 32'(gnt), 32'd0);
    tick();
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_gnt_buf", 32'(gnt_buf), 32'd2);
    check("t1_ref_grant", 32'(ref_buf_numbr), 32'd2);
    req = '0;
    tick();
    check("t1_gnt_pulse", 32'(gnt), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // Round-robin with all requests held.
    do_reset();
    buf_num_replc = 2'd0; req = 4'b1111; ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      tick();
      if (gnt != '0) begin
        gv[ng] = gnt; gt[ng] = c; ng++;
        if (ng == 5) req = '0;
      end
    end
    check("t2_count", 32'(ng), 32'd5);
    for (int i = 0; i < ng; i++) check("t2_order", 32'(gv[i]), 32'(e2[i]));
    for (int i = 1; i < ng; i++) check("t2_spacing", 32'(gt[i] - gt[i-1]), 32'd4);
    tick();

    // Dirty victim with write-back acknowledged.
    mark_dirty = 1'b1; mark_buf = 2'd1;
    tick();
    mark_dirty = 1'b0; req = 4'b0010; buf_num_replc = 2'd1;
    wait_sig(1, 10, n, ok);
    check("t3_wb_seen", 32'(ok), 32'd1);
    check("t3_wb_lat", 32'(n), 32'd3);
    check("t3_wb_buf", 32'(wb_buf), 32'd1);
    tick(); tick();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("t3_gnt", 32'(gnt), 32'b0010);
    check("t3_gnt_buf", 32'(gnt_buf), 32'd1);
    check("t3_wb_drop", 32'(wb_req), 32'd0);
    req = '0;
    tick();
    req = 4'b0100;
    wait_sig(0, 10, n, ok);
    check("t3_clean_after", 32'(n), 32'd3);
    check("t3_gnt2", 32'(gnt), 32'b0100);
    req = '0;
    tick();

    // Write-back timeout, retry keeps the round-robin pointer.
    mark_dirty = 1'b1; mark_buf = 2'd3;
    tick();
    mark_dirty = 1'b0; req = 4'b1001; buf_num_replc = 2'd3;
    wait_sig(1, 10, n, ok);
    check("t4_wb_seen", 32'(ok), 32'd1);
    m = 0; gseen = 1'b0;
    while (!err_wb_to && m < 40) begin
      tick(); m++;
      if (gnt != '0) gseen = 1'b1;
    end
    check("t4_err_seen", 32'(err_wb_to), 32'd1);
    check("t4_err_delay", 32'(m), 32'd15);
    check("t4_no_gnt", 32'(gseen), 32'd0);
    check("t4_wb_dropped", 32'(wb_req), 32'd0);
    wait_sig(1, 10, n, ok);
    check("t4_retry_wb", 32'(ok), 32'd1);
    check("t4_retry_lat", 32'(n), 32'd3);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("t4_gnt_rr_kept", 32'(gnt), 32'b1000);
    check("t4_gnt_buf", 32'(gnt_buf), 32'd3);
    req = 4'b0001;
    tick();
    wait_sig(0, 10, n, ok);
    check("t4_next_gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick();

    // Asynchronous reset during write-back.
    mark_dirty = 1'b1; mark_buf = 2'd2;
    tick();
    mark_dirty = 1'b0; req = 4'b0001; buf_num_replc = 2'd2;
    wait_sig(1, 10, n, ok);
    check("t5_wb_seen", 32'(ok), 32'd1);
    tick();
    rst_n = 1'b0; req = '0;
    #1;
    check("t5_wb_async", 32'(wb_req), 32'd0);
    check("t5_busy_async", 32'(busy), 32'd0);
    check("t5_new_async", 32'(new_buf_req), 32'd0);
    check("t5_gnt_async", 32'(gnt), 32'd0);
    tick();
    check("t5_gnt_held", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    tick();
    req = 4'b0001;
    wait_sig(0, 10, n, ok);
    check("t5_dirty_cleared", 32'(n), 32'd3);
    check("t5_gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick();

    // Mark wins over the grant-time clear.
    req = 4'b0001; buf_num_replc = 2'd0;
    wait_sig(0, 10, n, ok);
    check("t6_gnt", 32'(gnt), 32'b0001);
    check("t6_gnt_buf", 32'(gnt_buf), 32'd0);
    mark_dirty = 1'b1; mark_buf = 2'd0; req = '0;
    tick();
    mark_dirty = 1'b0;
    tick();
    req = 4'b0010;
    wait_sig(1, 10, n, ok);
    check("t6_wb_seen", 32'(ok), 32'd1);
    check("t6_wb_buf", 32'(wb_buf), 32'd0);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("t6_gnt2", 32'(gnt), 32'b0010);
    req = '0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
